nova_io_tty: RTL and testbench
==============================

// Module: nova_io_tty
// PURPOSE
//  Nova teletype I/O device on the CPU programmed-I/O bus: decodes device codes, implements
//  Nova busy/done semantics, serialises DOA bytes to 8N1 on txd, optionally receives 8N1 on rxd.
//  Sits downstream of nova_cpu's bs_* port, in parallel with nova_io_pio_snooper; drives irq.
// PARAMETERS
//  TTO_CODE  6'o11   device code of transmitter (DOA/NIOS/NIOC/SKP status)
//  TTI_CODE  6'o10   device code of receiver (only decoded with NOVA_TTY_RX_EN)
//  CLK_DIV   434     clk cycles per serial bit (50 MHz / 115200); legal range 4..65535
// PORTS
//  clk      in   1     system clock, all logic on rising edge
//  rst      in   1     asynchronous, active-high reset
//  bs_rst   in   1     bus IORST; synchronous clear, same effect as Clear on both codes
//  bs_stb   in   1     bus strobe, one cycle per I/O transfer
//  bs_we    in   1     1 = CPU writes (DOx/NIO control), 0 = CPU reads (DIx/status)
//  bs_adr   in   [0:7] [0:1] function: 00=A 01=B 10=C 11=S; [2:7] device code
//  bs_dout  in   [0:15] data from CPU; with function S write, [14:15] 01=Start 10=Clear 11=Pulse
//  bs_din   out  [0:15] data to CPU, combinational
//  txd      out  1     serial out, idle high
//  rxd      in   1     serial in, asynchronous (ignored without NOVA_TTY_RX_EN)
//  irq      out  1     level interrupt request
// BEHAVIOUR
//  Reset (rst, async): tx_busy=tx_done=rx_busy=rx_done=0, tx_hold=0, rx_buf=0, txd=1, irq=0,
//   counters=0, both FSMs IDLE. bs_rst: identical values, applied on the clock edge.
//  Transfer fires when bs_stb=1 and bs_adr[2:7] matches a decoded code; other codes: no effect, bs_din=0.
//  TTO write A: tx_hold <= bs_dout[8:15]; does not start. Writes B/C: ignored.
//  TTO Start: if !tx_busy -> tx_busy=1, tx_done=0, FSM leaves IDLE next cycle; if tx_busy, ignored.
//  TTO Clear: tx_busy=0, tx_done=0, FSM -> IDLE, txd=1 same edge (aborts frame). Pulse: no effect.
//  Start and Clear cannot coincide (one field); write A + Start = two transfers.
//  TX FSM: IDLE -> START(txd=0) -> DATA x8 (bs_dout[15] bit first, i.e. LSB) -> STOP(txd=1) -> IDLE.
//   Each state/bit lasts exactly CLK_DIV cycles; first start-bit cycle is the cycle after Start edge.
//   At end of STOP: tx_busy=0, tx_done=1 same edge. Frame = 10*CLK_DIV cycles.
//   tx_hold latched into shifter at START entry; DOA during frame changes next byte only.
//  Read S: bs_din[0]=busy, [1]=done of addressed code, rest 0. Read A on TTO: 0.
//  irq = tx_done | rx_done (registered flags, no extra delay). Clearing done drops irq next cycle.
//  Counters: 16-bit baud counter counts CLK_DIV-1 downto 0 then reloads; 4-bit bit index; no wrap past 8.
// CONFIGURATION
//  NOVA_TTY_RX_EN defined: receiver present at TTI_CODE.
//   rxd passes a 2-FF synchroniser (2-cycle latency). Start arms (rx_busy=1, rx_done=0); Clear
//   disarms. Armed and IDLE: falling edge -> wait CLK_DIV/2, recheck low (else back to IDLE, glitch);
//   then sample 8 data bits each CLK_DIV later, LSB first, then stop bit. Stop=1: rx_buf<=byte,
//   rx_busy=0, rx_done=1. Stop=0 (framing error): byte dropped, stays armed. Not armed: rxd ignored.
//   Read A on TTI: bs_din[8:15]=rx_buf, [0:7]=0; does not clear flags.
//  Not defined: no RX logic; TTI_CODE not decoded (bs_din=0); rx_busy=rx_done=0 constant; rxd unused.
// TESTING (CLK_DIV=4, 50 MHz clk)
//  rst pulse then idle -> txd=1, irq=0, bs_din=0; read S @11 -> 16'h0000.
//  DOA @11 16'h0041, Start @11 -> txd 0,1,0,0,0,0,0,1,0,1 each 4 cycles (40 total); busy=1 during,
//   then done=1, irq=1; read S -> 16'h4000.
//  Start mid-frame (cycle 12) -> ignored, frame unchanged; Clear at cycle 20 -> txd=1 same edge,
//   busy=done=0, irq stays 0; a new Start sends full frame.
//  Transfer to code 6'o12, and bs_rst mid-frame -> first: no state change; second: txd=1, flags 0.
//  RX_EN: Start @10, drive 8N1 16'h5A on rxd -> rx_done=1, irq=1, read A @10 -> 16'h005A;
//   1-cycle low glitch on rxd -> no reception; stop bit 0 -> rx_done stays 0, rx_busy stays 1.
//  Without RX_EN: same rxd stimulus -> irq=0, read A @10 -> 16'h0000.

Source files
------------

// File: rtl/nova_io_tty.sv
// nova_io_tty: Nova teletype device on the programmed-I/O bus with an 8N1 transmitter at TTO_CODE.
// Optional receiver at TTI_CODE is built when NOVA_TTY_RX_EN is defined.
module nova_io_tty #(
    parameter logic [5:0] TTO_CODE = 6'o11,
    parameter logic [5:0] TTI_CODE = 6'o10,
    parameter int         CLK_DIV  = 434
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_bs_rst,
    input  logic        i_bs_stb,
    input  logic        i_bs_we,
    input  logic [7:0]  i_bs_adr,
    input  logic [15:0] i_bs_dout,
    output logic [15:0] o_bs_din,
    output logic        o_txd,
    input  logic        i_rxd,
    output logic        o_irq
);

    // Buses are declared descending: Nova bit n sits at index 15-n (or 7-n on the address).
    localparam logic [1:0]  FN_A      = 2'b00;
    localparam logic [1:0]  FN_S      = 2'b11;
    localparam logic [1:0]  CTL_START = 2'b01;
    localparam logic [1:0]  CTL_CLEAR = 2'b10;
    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

    // IDLE | line idle, START | start bit, DATA | 8 data bits LSB first, STOP | stop bit
    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_START  = 2'd1;
    localparam logic [1:0]  ST_DATA   = 2'd2;
    localparam logic [1:0]  ST_STOP   = 2'd3;

    logic [1:0]  w_fn;
    logic [5:0]  w_dev;
    logic [1:0]  w_ctl;
    logic        w_tto_sel;
    logic        w_tto_doa;
    logic        w_tto_start;
    logic        w_tto_clear;
    logic        w_tx_tick;
    logic        w_rx_done;

    logic [1:0]  r_tx_state;
    logic [15:0] r_tx_cnt;
    logic [3:0]  r_tx_idx;
    logic [7:0]  r_tx_shift;
    logic [7:0]  r_tx_hold;
    logic        r_tx_busy;
    logic        r_tx_done;
    logic        r_txd;

    assign w_fn        = i_bs_adr[7:6];
    assign w_dev       = i_bs_adr[5:0];
    assign w_ctl       = i_bs_dout[1:0];
    assign w_tto_sel   = i_bs_stb && (w_dev == TTO_CODE);
    assign w_tto_doa   = w_tto_sel && i_bs_we && (w_fn == FN_A);
    assign w_tto_start = w_tto_sel && i_bs_we && (w_fn == FN_S) && (w_ctl == CTL_START);
    assign w_tto_clear = w_tto_sel && i_bs_we && (w_fn == FN_S) && (w_ctl == CTL_CLEAR);
    assign w_tx_tick   = (r_tx_cnt == 16'd0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx_hold  <= '0;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
            r_txd      <= 1'b1;
        end else if (i_bs_rst) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx_hold  <= '0;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
            r_txd      <= 1'b1;
        end else begin
            if (w_tto_doa) begin
                r_tx_hold <= i_bs_dout[7:0];
            end
            if (w_tto_clear) begin
                r_tx_state <= ST_IDLE;
                r_tx_cnt   <= '0;
                r_tx_idx   <= '0;
                r_tx_busy  <= 1'b0;
                r_tx_done  <= 1'b0;
                r_txd      <= 1'b1;
            end else begin
                case (r_tx_state)
                    ST_IDLE: begin
                        if (w_tto_start) begin
                            r_tx_state <= ST_START;
                            r_tx_cnt   <= BAUD_LAST;
                            r_tx_shift <= r_tx_hold;
                            r_tx_busy  <= 1'b1;
                            r_tx_done  <= 1'b0;
                            r_txd      <= 1'b0;
                        end
                    end
                    ST_START: begin
                        if (w_tx_tick) begin
                            r_tx_state <= ST_DATA;
                            r_tx_cnt   <= BAUD_LAST;
                            r_tx_idx   <= '0;
                            r_txd      <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        end else begin
                            r_tx_cnt <= r_tx_cnt - 16'd1;
                        end
                    end
                    ST_DATA: begin
                        if (w_tx_tick) begin
                            r_tx_cnt <= BAUD_LAST;
                            if (r_tx_idx == 4'd7) begin
                                r_tx_state <= ST_STOP;
                                r_txd      <= 1'b1;
                            end else begin
                                r_tx_idx   <= r_tx_idx + 4'd1;
                                r_txd      <= r_tx_shift[0];
                                r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            end
                        end else begin
                            r_tx_cnt <= r_tx_cnt - 16'd1;
                        end
                    end
                    default: begin
                        if (w_tx_tick) begin
                            r_tx_state <= ST_IDLE;
                            r_tx_busy  <= 1'b0;
                            r_tx_done  <= 1'b1;
                        end else begin
                            r_tx_cnt <= r_tx_cnt - 16'd1;
                        end
                    end
                endcase
            end
        end
    end

`ifdef NOVA_TTY_RX_EN
    localparam logic [15:0] BAUD_HALF = 16'(CLK_DIV / 2 - 1);

    logic        w_tti_sel;
    logic        w_tti_start;
    logic        w_tti_clear;
    logic        w_rx_fall;
    logic        w_rx_tick;
    logic        w_unused;

    logic        r_rx_s1;
    logic        r_rx_s2;
    logic        r_rx_prev;
    logic [1:0]  r_rx_state;
    logic [15:0] r_rx_cnt;
    logic [3:0]  r_rx_idx;
    logic [7:0]  r_rx_shift;
    logic [7:0]  r_rx_buf;
    logic        r_rx_busy;
    logic        r_rx_done;

    assign w_tti_sel   = i_bs_stb && (w_dev == TTI_CODE);
    assign w_tti_start = w_tti_sel && i_bs_we && (w_fn == FN_S) && (w_ctl == CTL_START);
    assign w_tti_clear = w_tti_sel && i_bs_we && (w_fn == FN_S) && (w_ctl == CTL_CLEAR);
    assign w_rx_fall   = r_rx_prev && !r_rx_s2;
    assign w_rx_tick   = (r_rx_cnt == 16'd0);
    assign w_rx_done   = r_rx_done;
    assign w_unused    = ^i_bs_dout[15:8];

    // Synchroniser powers up at the idle level so reset release never looks like a start bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= i_rxd;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
            r_rx_buf   <= '0;
            r_rx_busy  <= 1'b0;
            r_rx_done  <= 1'b0;
        end else if (i_bs_rst) begin
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
            r_rx_buf   <= '0;
            r_rx_busy  <= 1'b0;
            r_rx_done  <= 1'b0;
        end else if (w_tti_clear) begin
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_busy  <= 1'b0;
            r_rx_done  <= 1'b0;
        end else begin
            if (w_tti_start) begin
                r_rx_busy <= 1'b1;
                r_rx_done <= 1'b0;
            end
            case (r_rx_state)
                ST_IDLE: begin
                    if (r_rx_busy && w_rx_fall) begin
                        r_rx_state <= ST_START;
                        r_rx_cnt   <= BAUD_HALF;
                    end
                end
                ST_START: begin
                    if (w_rx_tick) begin
                        // A start bit that is high again at mid-bit was only a glitch.
                        if (!r_rx_s2) begin
                            r_rx_state <= ST_DATA;
                            r_rx_cnt   <= BAUD_LAST;
                            r_rx_idx   <= '0;
                        end else begin
                            r_rx_state <= ST_IDLE;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_cnt   <= BAUD_LAST;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        if (r_rx_idx == 4'd7) begin
                            r_rx_state <= ST_STOP;
                        end else begin
                            r_rx_idx <= r_rx_idx + 4'd1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 16'd1;
                    end
                end
                default: begin
                    if (w_rx_tick) begin
                        r_rx_state <= ST_IDLE;
                        if (r_rx_s2) begin
                            r_rx_buf  <= r_rx_shift;
                            r_rx_busy <= 1'b0;
                            r_rx_done <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        o_bs_din = '0;
        if (i_bs_stb && !i_bs_we) begin
            if (w_dev == TTO_CODE) begin
                if (w_fn == FN_S) begin
                    o_bs_din[15:14] = {r_tx_busy, r_tx_done};
                end
            end else if (w_dev == TTI_CODE) begin
                if (w_fn == FN_S) begin
                    o_bs_din[15:14] = {r_rx_busy, r_rx_done};
                end else if (w_fn == FN_A) begin
                    o_bs_din[7:0] = r_rx_buf;
                end
            end
        end
    end
`else
    logic w_unused;

    assign w_rx_done = 1'b0;
    assign w_unused  = (^i_bs_dout[15:8]) ^ i_rxd ^ (^TTI_CODE);

    always_comb begin
        o_bs_din = '0;
        if (i_bs_stb && !i_bs_we && (w_dev == TTO_CODE) && (w_fn == FN_S)) begin
            o_bs_din[15:14] = {r_tx_busy, r_tx_done};
        end
    end
`endif

    assign o_txd = r_txd;
    assign o_irq = r_tx_done | w_rx_done;

endmodule

// File: tb/tb_nova_io_tty.sv
// Bench for nova_io_tty at CLK_DIV=4: bus-transfer vector table, then transmit and receive sequences.
module tb_nova_io_tty;

    localparam int          DIV     = 4;
    localparam logic [5:0]  TTO     = 6'o11;
    localparam logic [5:0]  TTI     = 6'o10;
    localparam logic [5:0]  OTHER   = 6'o12;
    localparam logic [1:0]  FA      = 2'b00;
    localparam logic [1:0]  FB      = 2'b01;
    localparam logic [1:0]  FC      = 2'b10;
    localparam logic [1:0]  FS      = 2'b11;
    localparam logic [15:0] C_START = 16'h0001;
    localparam logic [15:0] C_CLEAR = 16'h0002;
    localparam logic [15:0] C_PULSE = 16'h0003;
`ifdef NOVA_TTY_RX_EN
    localparam bit RX = 1'b1;
`else
    localparam bit RX = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [1:0]  fn;
        logic [5:0]  code;
        logic [15:0] data;
        logic [15:0] exp_din;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        bs_rst;
    logic        bs_stb;
    logic        bs_we;
    logic [7:0]  bs_adr;
    logic [15:0] bs_dout;
    logic [15:0] bs_din;
    logic        txd;
    logic        rxd;
    logic        irq;

    int   n_pass  = 0;
    int   n_total = 0;
    logic q_txd[$];
    vec_t vt[16];

    nova_io_tty #(.TTO_CODE(TTO), .TTI_CODE(TTI), .CLK_DIV(DIV)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_bs_rst (bs_rst),
        .i_bs_stb (bs_stb),
        .i_bs_we  (bs_we),
        .i_bs_adr (bs_adr),
        .i_bs_dout(bs_dout),
        .o_bs_din (bs_din),
        .o_txd    (txd),
        .i_rxd    (rxd),
        .o_irq    (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 16'h%h, want 16'h%h", name, act, exp);
    endtask

    task automatic bus_drive(input logic we, input logic [1:0] fn, input logic [5:0] code,
                             input logic [15:0] data);
        bs_stb  = 1'b1;
        bs_we   = we;
        bs_adr  = {fn, code};
        bs_dout = data;
    endtask

    task automatic bus_idle();
        bs_stb  = 1'b0;
        bs_we   = 1'b0;
        bs_adr  = '0;
        bs_dout = '0;
    endtask

    task automatic xfer(input logic we, input logic [1:0] fn, input logic [5:0] code,
                        input logic [15:0] data, output logic [15:0] rd);
        @(negedge clk);
        bus_drive(we, fn, code, data);
        #1;
        rd = bs_din;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic wr(input logic [1:0] fn, input logic [5:0] code, input logic [15:0] data);
        logic [15:0] dummy;
        xfer(1'b1, fn, code, data, dummy);
    endtask

    task automatic rd_chk(input string name, input logic [1:0] fn, input logic [5:0] code,
                          input logic [15:0] exp);
        logic [15:0] rd;
        xfer(1'b0, fn, code, 16'h0000, rd);
        check(name, rd, exp);
    endtask

    task automatic push_frame(input logic [7:0] b);
        logic v;
        for (int i = 0; i < 10; i++) begin
            v = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
            repeat (DIV) q_txd.push_back(v);
        end
    endtask

    // Samples txd every cycle against the scoreboard; optional bus actions at given cycles.
    task automatic run_frame(input int n, input int k_doa, input logic [15:0] doa_val,
                             input int k_sta, input int k_clr, input int k_rst,
                             input int k_rd, input logic [15:0] rd_exp);
        logic e;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            bus_idle();
            bs_rst = 1'b0;
            e = (q_txd.size() > 0) ? q_txd.pop_front() : 1'b1;
            check($sformatf("txd_k%0d", k), {15'b0, txd}, {15'b0, e});
            if (k == k_doa) bus_drive(1'b1, FA, TTO, doa_val);
            else if (k == k_sta) bus_drive(1'b1, FS, TTO, C_START);
            else if (k == k_clr) begin
                bus_drive(1'b1, FS, TTO, C_CLEAR);
                q_txd.delete();
            end else if (k == k_rst) begin
                bs_rst = 1'b1;
                q_txd.delete();
            end else if (k == k_rd) begin
                bus_drive(1'b0, FS, TTO, 16'h0000);
                #1;
                check("rd_s_midframe", bs_din, rd_exp);
            end
        end
        @(negedge clk);
        bus_idle();
        bs_rst = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic v;
        for (int i = 0; i < 10; i++) begin
            v = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
            @(negedge clk);
            rxd = v;
            repeat (DIV - 1) @(negedge clk);
        end
        @(negedge clk);
        rxd = 1'b1;
    endtask

    initial begin
        logic [15:0] rd;

        vt[0]  = '{1'b0, FS, TTO,   16'h0000, 16'h0000};
        vt[1]  = '{1'b0, FA, TTO,   16'h0000, 16'h0000};
        vt[2]  = '{1'b1, FA, TTO,   16'h0041, 16'h0000};
        vt[3]  = '{1'b0, FS, TTO,   16'h0000, 16'h0000};
        vt[4]  = '{1'b1, FS, TTO,   C_PULSE,  16'h0000};
        vt[5]  = '{1'b0, FS, TTO,   16'h0000, 16'h0000};
        vt[6]  = '{1'b1, FB, TTO,   C_START,  16'h0000};
        vt[7]  = '{1'b1, FC, TTO,   C_START,  16'h0000};
        vt[8]  = '{1'b0, FS, TTO,   16'h0000, 16'h0000};
        vt[9]  = '{1'b1, FS, OTHER, C_START,  16'h0000};
        vt[10] = '{1'b0, FS, TTO,   16'h0000, 16'h0000};
        vt[11] = '{1'b0, FS, OTHER, 16'h0000, 16'h0000};
        vt[12] = '{1'b0, FS, TTI,   16'h0000, 16'h0000};
        vt[13] = '{1'b0, FA, TTI,   16'h0000, 16'h0000};
        vt[14] = '{1'b1, FS, TTO,   C_CLEAR,  16'h0000};
        vt[15] = '{1'b0, FS, TTO,   16'h0000, 16'h0000};

        rst    = 1'b1;
        bs_rst = 1'b0;
        rxd    = 1'b1;
        bus_idle();
        repeat (3) @(negedge clk);
        check("rst_txd", {15'b0, txd}, 16'h0001);
        check("rst_irq", {15'b0, irq}, 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        check("idle_din", bs_din, 16'h0000);
        check("idle_txd", {15'b0, txd}, 16'h0001);

        for (int i = 0; i < 16; i++) begin
            xfer(vt[i].we, vt[i].fn, vt[i].code, vt[i].data, rd);
            if (!vt[i].we) check($sformatf("vec%0d_din", i), rd, vt[i].exp_din);
            check($sformatf("vec%0d_txd", i), {15'b0, txd}, 16'h0001);
            check($sformatf("vec%0d_irq", i), {15'b0, irq}, 16'h0000);
        end

        // 0x41 frame; DOA of 0x55 mid-frame and a redundant Start must not disturb it.
        wr(FS, TTO, C_START);
        push_frame(8'h41);
        run_frame(40, 5, 16'h0055, 12, -1, -1, 20, 16'h8000);
        check("done_irq", {15'b0, irq}, 16'h0001);
        rd_chk("done_rd_s", FS, TTO, 16'h4000);

        // Restart clears done, then Clear aborts the frame.
        wr(FS, TTO, C_START);
        check("restart_irq", {15'b0, irq}, 16'h0000);
        push_frame(8'h55);
        run_frame(26, -1, 16'h0000, -1, 20, -1, -1, 16'h0000);
        repeat (30) @(negedge clk);
        check("clr_txd", {15'b0, txd}, 16'h0001);
        check("clr_irq", {15'b0, irq}, 16'h0000);
        rd_chk("clr_rd_s", FS, TTO, 16'h0000);

        wr(FS, TTO, C_START);
        push_frame(8'h55);
        run_frame(40, -1, 16'h0000, -1, -1, -1, -1, 16'h0000);
        rd_chk("frame55_rd_s", FS, TTO, 16'h4000);

        // IORST mid-frame also clears the holding register.
        wr(FA, TTO, 16'h00C3);
        wr(FS, TTO, C_START);
        push_frame(8'hC3);
        run_frame(16, -1, 16'h0000, -1, -1, 12, -1, 16'h0000);
        check("iorst_irq", {15'b0, irq}, 16'h0000);
        rd_chk("iorst_rd_s", FS, TTO, 16'h0000);
        wr(FS, TTO, C_START);
        push_frame(8'h00);
        run_frame(40, -1, 16'h0000, -1, -1, -1, -1, 16'h0000);
        check("hold0_irq", {15'b0, irq}, 16'h0001);
        rd_chk("hold0_rd_s", FS, TTO, 16'h4000);
        wr(FS, TTO, C_CLEAR);
        check("tto_clr_irq", {15'b0, irq}, 16'h0000);

        wr(FS, TTI, C_START);
        send_rx(8'h5A, 1'b1);
        repeat (8) @(negedge clk);
        check("rx_irq", {15'b0, irq}, RX ? 16'h0001 : 16'h0000);
        rd_chk("rx_rd_a", FA, TTI, RX ? 16'h005A : 16'h0000);
        rd_chk("rx_rd_s", FS, TTI, RX ? 16'h4000 : 16'h0000);

        wr(FS, TTI, C_START);
        check("rearm_irq", {15'b0, irq}, 16'h0000);
        @(negedge clk);
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (44) @(negedge clk);
        rd_chk("glitch_rd_s", FS, TTI, RX ? 16'h8000 : 16'h0000);
        check("glitch_irq", {15'b0, irq}, 16'h0000);

        send_rx(8'hA5, 1'b0);
        repeat (8) @(negedge clk);
        rd_chk("ferr_rd_s", FS, TTI, RX ? 16'h8000 : 16'h0000);
        check("ferr_irq", {15'b0, irq}, 16'h0000);
        rd_chk("ferr_rd_a", FA, TTI, RX ? 16'h005A : 16'h0000);

        send_rx(8'h3C, 1'b1);
        repeat (8) @(negedge clk);
        rd_chk("rx2_rd_a", FA, TTI, RX ? 16'h003C : 16'h0000);
        check("rx2_irq", {15'b0, irq}, RX ? 16'h0001 : 16'h0000);

        wr(FS, TTI, C_CLEAR);
        rd_chk("tti_clr_rd_s", FS, TTI, 16'h0000);
        check("tti_clr_irq", {15'b0, irq}, 16'h0000);
        check("end_txd", {15'b0, txd}, 16'h0001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
